// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL phase/lock detector.
// UNLOCK_CNT only matters when PLL_LOCK_HYST_EN is defined.
package pll_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REF_LEAD = 2'd1,
        FB_LEAD  = 2'd2
    } pll_state_e;

    localparam int UNLOCK_CNT = 4;

    function automatic int signed_abs(input int v);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/pll_edge_sync.sv
// N-flop synchronizer followed by a registered rising-edge pulse.
// A rising edge on din produces a one-cycle pulse N+1 cycles after it is first sampled.
module pll_edge_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [N-1:0] sync;
    logic         last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            last <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[N-2:0], din};
            last <= sync[N-1];
            rise <= sync[N-1] & ~last;
        end
    end

endmodule

// File: rtl/pll_phase_lock_detect.sv
// Phase error measurement between clk_ref and clk_fb, with up/dn pulses and lock flag.
// Define PLL_LOCK_HYST_EN to require UNLOCK_CNT consecutive bad measurements before unlocking.
module pll_phase_lock_detect
    import pll_pkg::*;
#(
    parameter int CNT_W    = 6,
    parameter int TIMEOUT  = 20,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 16
) (
    input  logic                    clk_out,
    input  logic                    rst_n,
    input  logic                    clk_ref,
    input  logic                    clk_fb,
    output logic signed [CNT_W-1:0] phase_err,
    output logic                    err_valid,
    output logic                    up,
    output logic                    dn,
    output logic                    locked,
    output pll_state_e              state_dbg
);

    localparam int LCK_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]        TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic signed [CNT_W-1:0] ERR_MAX   = CNT_W'(TIMEOUT);

    logic ref_rise;
    logic fb_rise;
    logic clk_fb_d;

    pll_state_e       state;
    pll_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic                    meas_valid;
    logic signed [CNT_W-1:0] meas_err;
    logic                    meas_good;

    logic [LCK_W-1:0] lock_cnt;
    logic [LCK_W-1:0] lock_inc;

    pll_edge_sync #(.N(2)) u_ref_sync (
        .clk   (clk_out),
        .rst_n (rst_n),
        .din   (clk_ref),
        .rise  (ref_rise)
    );

    // clk_fb is already in the clk_out domain, so a single delay flop suffices.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) clk_fb_d <= 1'b0;
        else        clk_fb_d <= clk_fb;
    end

    assign fb_rise   = clk_fb & ~clk_fb_d;
    assign state_dbg = state;

    // Decide whether this cycle closes a measurement and with what value.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        meas_valid = 1'b0;
        meas_err   = '0;
        unique case (state)
            IDLE: begin
                if (ref_rise && fb_rise) begin
                    meas_valid = 1'b1;
                end else if (ref_rise) begin
                    state_nxt = REF_LEAD;
                    cnt_nxt   = CNT_W'(1);
                end else if (fb_rise) begin
                    state_nxt = FB_LEAD;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            REF_LEAD: begin
                if (fb_rise) begin
                    meas_valid = 1'b1;
                    meas_err   = $signed(cnt);
                    if (ref_rise) begin
                        cnt_nxt = CNT_W'(1);
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else if (ref_rise) begin
                    meas_valid = 1'b1;
                    meas_err   = ERR_MAX;
                    cnt_nxt    = CNT_W'(1);
                end else if (cnt == TIMEOUT_V) begin
                    meas_valid = 1'b1;
                    meas_err   = ERR_MAX;
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            FB_LEAD: begin
                if (ref_rise) begin
                    meas_valid = 1'b1;
                    meas_err   = -$signed(cnt);
                    if (fb_rise) begin
                        cnt_nxt = CNT_W'(1);
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else if (fb_rise) begin
                    meas_valid = 1'b1;
                    meas_err   = -ERR_MAX;
                    cnt_nxt    = CNT_W'(1);
                end else if (cnt == TIMEOUT_V) begin
                    meas_valid = 1'b1;
                    meas_err   = -ERR_MAX;
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign meas_good = (signed_abs(int'(meas_err)) <= TOL);
    assign lock_inc  = (lock_cnt == LCK_W'(LOCK_CNT)) ? lock_cnt : lock_cnt + LCK_W'(1);

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            phase_err <= '0;
            err_valid <= 1'b0;
            up        <= 1'b0;
            dn        <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            err_valid <= meas_valid;
            up        <= meas_valid && (meas_err > 0);
            dn        <= meas_valid && (meas_err < 0);
            if (meas_valid) phase_err <= meas_err;
        end
    end

`ifdef PLL_LOCK_HYST_EN
    localparam int BAD_W = $clog2(UNLOCK_CNT);
    logic [BAD_W-1:0] bad_cnt;

    // While locked, bad measurements are tolerated until UNLOCK_CNT in a row.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
            bad_cnt  <= '0;
        end else if (meas_valid) begin
            if (meas_good) begin
                bad_cnt  <= '0;
                lock_cnt <= lock_inc;
                locked   <= (lock_inc == LCK_W'(LOCK_CNT));
            end else if (locked && (bad_cnt != BAD_W'(UNLOCK_CNT - 1))) begin
                bad_cnt <= bad_cnt + BAD_W'(1);
            end else begin
                bad_cnt  <= '0;
                lock_cnt <= '0;
                locked   <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (meas_valid) begin
            if (meas_good) begin
                lock_cnt <= lock_inc;
                locked   <= (lock_inc == LCK_W'(LOCK_CNT));
            end else begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end
        end
    end
`endif

endmodule
